// File: rtl/tcm_pkg.sv
// Shared types and helpers for the test-completion monitor.
package tcm_pkg;

  localparam int unsigned MAX_CHANNELS = 32;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    RSN_NONE,
    RSN_CHANNEL,
    RSN_TIMEOUT,
    RSN_HANG
  } reason_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set(input logic [MAX_CHANNELS-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcm_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes its next value for
// same-cycle threshold checks.
module tcm_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign cnt_nxt_c_o = cnt_d;

endmodule

// File: rtl/test_completion_monitor.sv
// Harness completion controller: holds the DUT in reset, then folds channel
// results, a cycle timeout and a hang watchdog into one sticky verdict.
module test_completion_monitor
  import tcm_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned CYCLE_W           = 64,
  parameter int unsigned HANG_W            = 32,
  parameter int unsigned CODE_W            = 8,
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic [CYCLE_W-1:0]             cfg_max_cycles_i,
  input  logic [HANG_W-1:0]              cfg_hang_limit_i,
  input  logic                           cfg_mode_all_i,
  input  logic [NUM_CHANNELS-1:0]        cfg_chan_enable_i,
  input  logic [NUM_CHANNELS-1:0]        chan_success_i,
  input  logic [NUM_CHANNELS-1:0]        chan_failure_i,
  input  logic [NUM_CHANNELS*CODE_W-1:0] chan_fail_code_i,
  input  logic [NUM_CHANNELS-1:0]        chan_progress_i,
  output logic                           dut_reset_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           fail_o,
  output logic [1:0]                     fail_reason_o,
  output logic [CHAN_W-1:0]              fail_chan_o,
  output logic [CODE_W-1:0]              fail_code_o,
  output logic [CYCLE_W-1:0]             cycle_count_o,
  output logic [NUM_CHANNELS-1:0]        success_mask_o,
  output logic                           finish_pulse_o
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  state_e                  state_q, state_d;
  reason_e                 reason_q, reason_d;
  logic [CHAN_W-1:0]       chan_q, chan_d;
  logic [CODE_W-1:0]       code_q, code_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic dut_reset_q, dut_reset_d, running_q, running_d, done_q, done_d;
  logic pass_q, pass_d, fail_q, fail_d, finish_q, finish_d;

  logic [CYCLE_W-1:0]      cycle_q, cycle_nxt;
  logic [HANG_W-1:0]       hang_q, hang_nxt;
  logic [HOLD_W-1:0]       hold_q, hold_nxt;

  logic [NUM_CHANNELS-1:0] fail_vec_c, succ_vec_c, prog_vec_c;
  int unsigned             low_idx_c;
  logic [CODE_W-1:0]       low_code_c;
  logic                    in_run_c, all_ok_c, any_ok_c;

  assign in_run_c   = (state_q == ST_RUN);
  assign fail_vec_c = chan_failure_i  & cfg_chan_enable_i;
  assign succ_vec_c = chan_success_i  & cfg_chan_enable_i;
  assign prog_vec_c = chan_progress_i & cfg_chan_enable_i;

  tcm_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk_i       (clock_i),
    .rst_ni      (reset_n_i),
    .clr_i       (1'b0),
    .en_i        (state_q == ST_HOLD),
    .cnt_o       (hold_q),
    .cnt_nxt_c_o (hold_nxt)
  );

  tcm_sat_counter #(.W(CYCLE_W)) u_cycle_cnt (
    .clk_i       (clock_i),
    .rst_ni      (reset_n_i),
    .clr_i       (1'b0),
    .en_i        (in_run_c),
    .cnt_o       (cycle_q),
    .cnt_nxt_c_o (cycle_nxt)
  );

  tcm_sat_counter #(.W(HANG_W)) u_hang_cnt (
    .clk_i       (clock_i),
    .rst_ni      (reset_n_i),
    .clr_i       (in_run_c && (|prog_vec_c)),
    .en_i        (in_run_c),
    .cnt_o       (hang_q),
    .cnt_nxt_c_o (hang_nxt)
  );

  // Only the next values of the hold and hang counters drive decisions.
  logic unused_cnt;
  assign unused_cnt = ^{hold_q, hang_q};

  // Failure code of the lowest-indexed failing channel.
  always_comb begin
    low_idx_c  = lowest_set(MAX_CHANNELS'(fail_vec_c));
    low_code_c = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (i == low_idx_c) low_code_c = chan_fail_code_i[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    chan_d   = chan_q;
    code_d   = code_q;
    mask_d   = mask_q;
    all_ok_c = 1'b0;
    any_ok_c = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (hold_nxt == HOLD_W'(RESET_HOLD_CYCLES)) state_d = ST_RUN;
      end
      ST_RUN: begin
        mask_d   = mask_q | succ_vec_c;
        all_ok_c = (cfg_chan_enable_i != '0) &&
                   ((mask_d & cfg_chan_enable_i) == cfg_chan_enable_i);
        any_ok_c = |succ_vec_c;
        // Failure sources outrank success, in fixed priority.
        if (|fail_vec_c) begin
          state_d  = ST_FAIL;
          reason_d = RSN_CHANNEL;
          chan_d   = CHAN_W'(low_idx_c);
          code_d   = low_code_c;
        end else if ((cfg_max_cycles_i != '0) && (cycle_nxt > cfg_max_cycles_i)) begin
          state_d  = ST_FAIL;
          reason_d = RSN_TIMEOUT;
        end else if ((cfg_hang_limit_i != '0) && (hang_nxt > cfg_hang_limit_i)) begin
          state_d  = ST_FAIL;
          reason_d = RSN_HANG;
        end else if (cfg_mode_all_i ? all_ok_c : any_ok_c) begin
          state_d  = ST_PASS;
        end
      end
      default: ;
    endcase

    dut_reset_d = (state_d == ST_HOLD);
    running_d   = (state_d == ST_RUN);
    pass_d      = (state_d == ST_PASS);
    fail_d      = (state_d == ST_FAIL);
    done_d      = pass_d || fail_d;
    finish_d    = in_run_c && done_d;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_HOLD;
      reason_q    <= RSN_NONE;
      chan_q      <= '0;
      code_q      <= '0;
      mask_q      <= '0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      chan_q      <= chan_d;
      code_q      <= code_d;
      mask_q      <= mask_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      finish_q    <= finish_d;
    end
  end

  assign dut_reset_o    = dut_reset_q;
  assign running_o      = running_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign fail_reason_o  = reason_q;
  assign fail_chan_o    = chan_q;
  assign fail_code_o    = code_q;
  assign cycle_count_o  = cycle_q;
  assign success_mask_o = mask_q;
  assign finish_pulse_o = finish_q;

endmodule

// File: tb/tb_test_completion_monitor.sv
// Directed bench for test_completion_monitor with a verdict scoreboard.
module tb_test_completion_monitor;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CYW  = 64;
  localparam int unsigned HW   = 32;
  localparam int unsigned CW   = 8;
  localparam int unsigned HOLD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CYW-1:0]    cfg_max;
  logic [HW-1:0]     cfg_hang;
  logic              cfg_all;
  logic [NCH-1:0]    cfg_en;
  logic [NCH-1:0]    succ, failv, prog;
  logic [NCH*CW-1:0] codes;

  logic           dut_reset, running, done, pass, fail, finish_pulse;
  logic [1:0]     fail_reason, fail_chan;
  logic [CW-1:0]  fail_code;
  logic [CYW-1:0] cycle_count;
  logic [NCH-1:0] success_mask;

  test_completion_monitor #(
    .NUM_CHANNELS(NCH), .CYCLE_W(CYW), .HANG_W(HW), .CODE_W(CW),
    .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .cfg_max_cycles_i(cfg_max), .cfg_hang_limit_i(cfg_hang),
    .cfg_mode_all_i(cfg_all), .cfg_chan_enable_i(cfg_en),
    .chan_success_i(succ), .chan_failure_i(failv),
    .chan_fail_code_i(codes), .chan_progress_i(prog),
    .dut_reset_o(dut_reset), .running_o(running), .done_o(done),
    .pass_o(pass), .fail_o(fail), .fail_reason_o(fail_reason),
    .fail_chan_o(fail_chan), .fail_code_o(fail_code),
    .cycle_count_o(cycle_count), .success_mask_o(success_mask),
    .finish_pulse_o(finish_pulse)
  );

  typedef struct packed {
    logic           pass;
    logic [1:0]     reason;
    logic [1:0]     chan;
    logic [CW-1:0]  code;
    logic [CYW-1:0] cycle;
    logic [NCH-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      step();
      cyc++;
    end
  endtask

  task automatic idle();
    succ  = '0;
    failv = '0;
    prog  = '0;
    codes = '0;
  endtask

  task automatic push_exp(input logic p, input logic [1:0] r, input logic [1:0] ch,
                          input logic [CW-1:0] cd, input logic [CYW-1:0] cy,
                          input logic [NCH-1:0] m);
    exp_t e;
    e.pass = p; e.reason = r; e.chan = ch; e.code = cd; e.cycle = cy; e.mask = m;
    sb.push_back(e);
  endtask

  // Async reset check, then the full hold sequence up to the first RUN cycle.
  task automatic reset_and_hold();
    rst_n = 1'b0;
    #2;
    chk("rst_dut_reset", 64'(dut_reset), 64'(1));
    chk("rst_flags", 64'({running, done, pass, fail, finish_pulse}), 64'(0));
    chk("rst_fields", 64'({fail_reason, fail_chan, fail_code, success_mask}), 64'(0));
    chk("rst_cycle", cycle_count, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= int'(HOLD); i++) begin
      step();
      if (i < int'(HOLD)) chk("hold_phase", 64'({dut_reset, running}), 64'(2'b10));
      else                chk("hold_exit", 64'({dut_reset, running}), 64'(2'b01));
    end
    cyc = 0;
    chk("run_start_cycle", cycle_count, 64'(0));
  endtask

  // Wait for the verdict, pop the scoreboard, then confirm it is frozen.
  task automatic wait_verdict(input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (!finish_pulse && n < budget) begin
      step();
      n++;
    end
    chk("verdict_seen", 64'(finish_pulse), 64'(1));
    chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("v_flags", 64'({pass, fail, done, running, dut_reset}),
          64'({e.pass, !e.pass, 1'b1, 1'b0, 1'b0}));
      chk("v_reason", 64'(fail_reason), 64'(e.reason));
      chk("v_chan", 64'(fail_chan), 64'(e.chan));
      chk("v_code", 64'(fail_code), 64'(e.code));
      chk("v_cycle", cycle_count, e.cycle);
      chk("v_mask", 64'(success_mask), 64'(e.mask));
      succ  = '1;
      failv = '1;
      prog  = '1;
      codes = '1;
      step();
      chk("pulse_one_cycle", 64'(finish_pulse), 64'(0));
      step();
      chk("frozen_flags", 64'({pass, fail, done}), 64'({e.pass, !e.pass, 1'b1}));
      chk("frozen_fields", 64'({fail_reason, fail_chan, fail_code, success_mask}),
          64'({e.reason, e.chan, e.code, e.mask}));
      chk("frozen_cycle", cycle_count, e.cycle);
      idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    cfg_max  = '0;
    cfg_hang = '0;
    cfg_all  = 1'b0;
    cfg_en   = 4'b1111;
    idle();
    #1;

    // ANY mode, success on channel 2 at cycle 50.
    reset_and_hold();
    adv(1);
    chk("first_run_cycle", cycle_count, 64'(1));
    adv(48);
    chk("any_not_done", 64'({done, cycle_count == 64'(cyc)}), 64'(2'b01));
    succ = 4'b0100;
    push_exp(1'b1, 2'd0, 2'd0, 8'h00, 64'(50), 4'b0100);
    adv(1);
    idle();
    wait_verdict(5);

    // ALL mode over channels 0 and 1; channel 3 is masked off.
    cfg_all = 1'b1;
    cfg_en  = 4'b0011;
    reset_and_hold();
    adv(4);  succ = 4'b1000; adv(1); idle();
    adv(4);  succ = 4'b0001; adv(1); idle();
    chk("all_mask_ch0", 64'(success_mask), 64'(4'b0001));
    adv(9);  succ = 4'b1000; adv(1); idle();
    chk("all_mask_ignore3", 64'({done, success_mask}), 64'(5'b0_0001));
    adv(9);
    chk("all_not_done_29", 64'({done, cycle_count == 64'(29)}), 64'(2'b01));
    succ = 4'b0010;
    push_exp(1'b1, 2'd0, 2'd0, 8'h00, 64'(30), 4'b0011);
    adv(1);
    idle();
    wait_verdict(5);

    // Channel failure beats success; lowest enabled failing channel wins.
    cfg_all = 1'b0;
    cfg_en  = 4'b1011;
    reset_and_hold();
    adv(7);  failv = 4'b0100; codes = 32'h0000_EE00; adv(1); idle();
    chk("disabled_fail_ignored", 64'({done, running}), 64'(2'b01));
    adv(6);
    failv = 4'b1010;
    succ  = 4'b0001;
    codes = {8'hA5, 8'h77, 8'h3C, 8'h11};
    push_exp(1'b0, 2'd1, 2'd1, 8'h3C, 64'(15), 4'b0001);
    adv(1);
    idle();
    wait_verdict(5);

    // Timeout with no success.
    cfg_en  = 4'b1111;
    cfg_max = 64'(100);
    reset_and_hold();
    push_exp(1'b0, 2'd2, 2'd0, 8'h00, 64'(101), 4'b0000);
    wait_verdict(150);

    // Hang: enabled progress stops after cycle 40; disabled progress continues.
    cfg_max  = '0;
    cfg_hang = 32'(20);
    cfg_en   = 4'b0111;
    reset_and_hold();
    prog = 4'b0001;
    adv(40);
    prog = 4'b1000;
    push_exp(1'b0, 2'd3, 2'd0, 8'h00, 64'(61), 4'b0000);
    wait_verdict(40);
    idle();

    // Mid-run reset returns everything to reset values and repeats hold.
    cfg_hang = '0;
    cfg_en   = 4'b1111;
    reset_and_hold();
    adv(70);
    chk("mid_run_cycle", 64'({running, cycle_count == 64'(70)}), 64'(2'b11));
    reset_and_hold();
    adv(1);
    chk("after_rerun_cycle", cycle_count, 64'(1));

    // Empty enable mask never passes; ends only on timeout.
    cfg_en  = 4'b0000;
    cfg_max = 64'(30);
    reset_and_hold();
    succ = 4'b1111;
    push_exp(1'b0, 2'd2, 2'd0, 8'h00, 64'(31), 4'b0000);
    wait_verdict(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
